// File: rtl/counter_ctrl.sv
// counter_ctrl: up/down counter stepped by a prescaled tick (RUN) or a button
// (PAUSE), with debounced button controls, wrap/saturate modes and status LEDs.
module counter_ctrl #(
   parameter int BITS      = 4,
   parameter int LOG2DELAY = 18,
   parameter int DEBOUNCE  = 65536,
   parameter int PRESET    = 2 ** (BITS - 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      sw,
   input  logic [3:0]      btn,
   output logic [BITS-1:0] led,
   output logic            wrap,
   output logic            led4_r,
   output logic            led4_g,
   output logic            led4_b,
   output logic            led5_r,
   output logic            led5_g,
   output logic            led5_b
);

   localparam int                CNT_W      = $clog2(DEBOUNCE);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE - 1);
   localparam logic [BITS-1:0]   VAL_MAX    = '1;
   localparam logic [BITS-1:0]   VAL_PRESET = BITS'(PRESET);

   typedef enum logic {RUN, PAUSE} state_t;

   logic [1:0]           sw_meta;
   logic [1:0]           sw_sync;
   logic [3:0]           btn_meta;
   logic [3:0]           btn_sync;
   logic [3:0]           press;
   logic [LOG2DELAY-1:0] presc;
   logic                 tick;
   state_t               state;
   state_t               state_nxt;
   logic [BITS-1:0]      value;
   logic [BITS-1:0]      value_nxt;
   logic                 wrap_nxt;
   logic                 step;
   logic                 dir_down;
   logic                 sat_mode;
   logic                 at_max;
   logic                 at_min;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         // NOTE: non-blocking so the two stages form a real two-flop chain
         // rather than collapsing into a single register.
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
         btn_meta <= btn;
         btn_sync <= btn_meta;
      end
   end

   // A level is accepted after DEBOUNCE consecutive differing samples; a
   // press pulse is emitted on the accepted rising edge only.
   for (genvar i = 0; i < 4; i++) begin : g_debounce
      logic [CNT_W-1:0] cnt;
      logic             level;
      logic             pulse;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
         end else begin
            pulse <= 1'b0;
            if (btn_sync[i] == level) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt   <= '0;
               level <= btn_sync[i];
               pulse <= btn_sync[i];
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end

      assign press[i] = pulse;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) presc <= '0;
      else     presc <= presc + LOG2DELAY'(1);
   end

   assign tick = &presc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      state_nxt = state;
      if (press[0]) state_nxt = (state == RUN) ? PAUSE : RUN;
   end

   assign dir_down = sw_sync[0];
   assign sat_mode = sw_sync[1];
   assign at_max   = (value == VAL_MAX);
   assign at_min   = (value == '0);
   assign step     = (state == RUN) ? tick : press[2];

   // Priority: clear > load > step.
   always_comb begin
      value_nxt = value;
      wrap_nxt  = 1'b0;
      if (press[1]) begin
         value_nxt = '0;
      end else if (press[3]) begin
         value_nxt = VAL_PRESET;
      end else if (step) begin
         if (!dir_down) begin
            if (!at_max) begin
               value_nxt = value + BITS'(1);
            end else if (!sat_mode) begin
               value_nxt = '0;
               wrap_nxt  = 1'b1;
            end
         end else begin
            if (!at_min) begin
               value_nxt = value - BITS'(1);
            end else if (!sat_mode) begin
               value_nxt = VAL_MAX;
               wrap_nxt  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
         wrap  <= 1'b0;
      end else begin
         value <= value_nxt;
         wrap  <= wrap_nxt;
      end
   end

   assign led    = value;
   assign led4_r = (state == PAUSE);
   assign led4_g = (state == RUN);
   assign led4_b = sat_mode && (dir_down ? at_min : at_max);
   assign led5_g = !dir_down;
   assign led5_r = dir_down;
   assign led5_b = sat_mode;

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomised scoreboard bench for counter_ctrl: a behavioural model schedules
// expected value/state events; a negedge monitor matches them against the DUT.
module tb_counter_ctrl;

   localparam int BITS      = 4;
   localparam int LOG2DELAY = 2;
   localparam int DEBOUNCE  = 4;
   localparam int PRESET    = 8;
   localparam int PERIOD    = 2 ** LOG2DELAY;
   localparam int LAT       = DEBOUNCE + 3;
   localparam int MAXV      = 2 ** BITS - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      sw  = 2'b00;
   logic [3:0]      btn = 4'b0000;
   logic [BITS-1:0] led;
   logic            wrap;
   logic            led4_r, led4_g, led4_b, led5_r, led5_g, led5_b;

   counter_ctrl #(
      .BITS(BITS), .LOG2DELAY(LOG2DELAY), .DEBOUNCE(DEBOUNCE), .PRESET(PRESET)
   ) dut (
      .clk(clk), .rst(rst), .sw(sw), .btn(btn), .led(led), .wrap(wrap),
      .led4_r(led4_r), .led4_g(led4_g), .led4_b(led4_b),
      .led5_r(led5_r), .led5_g(led5_g), .led5_b(led5_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int e;
      int val;
      bit wrp;
      bit run;
   } exp_t;

   typedef struct {
      int         e;
      logic [1:0] v;
   } sw_ev_t;

   exp_t   exp_q[$];
   sw_ev_t sw_q[$];

   int cyc   = 0;
   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model state
   bit         m_rst    = 1'b1;
   int         rel_edge = 0;
   int         m_val    = 0;
   bit         m_run    = 1'b1;
   logic [1:0] m_sw     = 2'b00;
   int         press_at[4] = '{-1, -1, -1, -1};

   task automatic check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, req);
      end
   endtask

   // Expected effect of clock edge e: switches act 3 edges after being driven,
   // button presses LAT edges after their final clean edge, ticks every PERIOD.
   task automatic model_edge(int e);
      bit   p[4];
      bit   tick;
      bit   step;
      bit   wrapped;
      int   old_val;
      bit   old_run;
      exp_t x;
      if (m_rst) return;
      while (sw_q.size() > 0 && sw_q[0].e + 3 <= e) begin
         m_sw = sw_q[0].v;
         sw_q.delete(0);
      end
      for (int b = 0; b < 4; b++) begin
         p[b] = (press_at[b] == e);
         if (p[b]) press_at[b] = -1;
      end
      tick    = ((e - rel_edge) % PERIOD) == 0;
      step    = m_run ? tick : p[2];
      wrapped = 1'b0;
      old_val = m_val;
      old_run = m_run;
      if (p[1])
         m_val = 0;
      else if (p[3])
         m_val = PRESET;
      else if (step) begin
         if (m_sw[0] == 1'b0) begin
            if (m_val < MAXV) m_val = m_val + 1;
            else if (m_sw[1] == 1'b0) begin m_val = 0; wrapped = 1'b1; end
         end else begin
            if (m_val > 0) m_val = m_val - 1;
            else if (m_sw[1] == 1'b0) begin m_val = MAXV; wrapped = 1'b1; end
         end
      end
      if (p[0]) m_run = !m_run;
      if (m_val != old_val || wrapped || m_run != old_run) begin
         x.e = e; x.val = m_val; x.wrp = wrapped; x.run = m_run;
         exp_q.push_back(x);
      end
   endtask

   task automatic clk_step(int n = 1);
      repeat (n) begin
         @(posedge clk);
         cyc++;
         model_edge(cyc);
         #1;
      end
   endtask

   task automatic set_sw(logic [1:0] v);
      sw_ev_t s;
      sw = v;
      s.e = cyc; s.v = v;
      sw_q.push_back(s);
   endtask

   task automatic press(logic [3:0] mask, bit glitch);
      if (glitch) begin
         btn = btn | mask;
         clk_step();
         btn = btn & ~mask;
         clk_step();
      end
      btn = btn | mask;
      for (int b = 0; b < 4; b++) if (mask[b]) press_at[b] = cyc + LAT;
      clk_step(LAT + 3);
      btn = btn & ~mask;
      clk_step(LAT + 3);
   endtask

   // Press whose effect lands on the edge just checked; optionally aligned to a tick.
   task automatic press_probe(logic [3:0] mask, bit align, int want, string name);
      int t;
      if (align) while (((cyc + LAT - rel_edge) % PERIOD) != 0) clk_step();
      btn = btn | mask;
      for (int b = 0; b < 4; b++) if (mask[b]) press_at[b] = cyc + LAT;
      t = cyc + LAT;
      while (cyc < t) clk_step();
      check({name, "_led"}, led, want);
      check({name, "_wrap"}, wrap, 0);
      clk_step(3);
      btn = btn & ~mask;
      clk_step(LAT + 3);
   endtask

   task automatic do_reset(int n);
      sw_ev_t s;
      @(negedge clk);
      #1;
      rst = 1'b1;
      m_rst = 1'b1; m_val = 0; m_run = 1'b1; m_sw = 2'b00;
      sw_q.delete();
      press_at = '{-1, -1, -1, -1};
      #1;
      check("rst_led", led, 0);
      check("rst_wrap", wrap, 0);
      check("rst_run", led4_g, 1);
      check("rst_pause", led4_r, 0);
      clk_step(n);
      check("rst_hold_led", led, 0);
      check("rst_hold_run", led4_g, 1);
      rst = 1'b0;
      m_rst = 1'b0;
      rel_edge = cyc;
      s.e = cyc; s.v = sw;
      sw_q.push_back(s);
      for (int b = 0; b < 4; b++) if (btn[b]) press_at[b] = cyc + LAT;
   endtask

   // Monitor: any value change, wrap pulse or state change must match the
   // head of the expected queue, stamped with the same clock edge.
   logic [BITS-1:0] prev_led;
   logic            prev_g;
   always @(negedge clk) begin
      if (rst) begin
         prev_led = led;
         prev_g   = led4_g;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].e < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missed_event: led=%0d wrap=%0d due at cycle %0d, not seen by cycle %0d",
                     exp_q[0].val, exp_q[0].wrp, exp_q[0].e, cyc);
            exp_q.delete(0);
         end
         if (led !== prev_led || wrap !== 1'b0 || led4_g !== prev_g) begin
            if (exp_q.size() == 0 || exp_q[0].e != cyc) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_event at cycle %0d: led=%0d wrap=%0d run=%0d, none expected",
                        cyc, led, wrap, led4_g);
            end else begin
               exp_t x;
               x = exp_q.pop_front();
               check("event_led", led, x.val);
               check("event_wrap", wrap, x.wrp);
               check("event_run", led4_g, x.run);
               check("event_pause", led4_r, !x.run);
            end
         end
         prev_led = led;
         prev_g   = led4_g;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      int t;

      // Reset, then free count up through one full wrap.
      do_reset(3);
      clk_step(16 * PERIOD + 2);
      check("count_full_cycle", led, m_val);

      // Saturate-down at zero holds; wrap-down from zero goes to max.
      sw = 2'b11;
      do_reset(2);
      clk_step(12);
      check("sat_zero_led", led, 0);
      check("sat_zero_wrap", wrap, 0);
      check("sat_zero_led4_b", led4_b, 1);
      check("cfg_red_down", led5_r, 1);
      check("cfg_green_up", led5_g, 0);
      check("cfg_blue_sat", led5_b, 1);
      set_sw(2'b01);
      clk_step(2 * PERIOD + 1);
      check("wrap_down_led", led, m_val);
      check("wrap_mode_led4_b", led4_b, 0);
      set_sw(2'b00);
      clk_step(3);

      // Glitchy btn[0] gives exactly one toggle into PAUSE; value frozen.
      press(4'b0001, 1'b1);
      check("glitch_pause_r", led4_r, 1);
      check("glitch_pause_g", led4_g, 0);
      v = m_val;
      clk_step(3 * PERIOD);
      check("pause_frozen", led, v);

      // Three manual steps in PAUSE, back to RUN, manual step ignored.
      v = m_val;
      repeat (3) press(4'b0100, 1'b0);
      check("pause_three_steps", led, (v + 3) % (MAXV + 1));
      press(4'b0001, 1'b0);
      check("back_to_run", led4_g, 1);
      press(4'b0100, 1'b0);

      // Clear and load on a tick edge: clear wins; then load alone.
      press_probe(4'b1010, 1'b1, 0, "clear_load_tick");
      press_probe(4'b1000, 1'b0, PRESET, "load_alone");

      // Random switches, presses and glitches against the model.
      repeat (40) begin
         case ($urandom_range(0, 3))
            0: set_sw(2'($urandom_range(0, 3)));
            1: press(4'($urandom_range(1, 15)), 1'b0);
            2: clk_step($urandom_range(1, 10));
            default: press(4'(1 << $urandom_range(0, 3)), 1'b1);
         endcase
      end

      // Reset in the middle of a btn[3] debounce with the button kept held.
      set_sw(2'b00);
      clk_step(4);
      btn = 4'b1000;
      press_at[3] = cyc + LAT;
      clk_step(3);
      do_reset(2);
      t = cyc + LAT;
      while (cyc < t) clk_step();
      check("reset_held_load", led, PRESET);
      btn = 4'b0000;
      clk_step(LAT + 3);

      clk_step(10);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
